// File: rtl/gate_checker.sv
// gate_checker
// Exhaustively exercises an external 2-input gate. Each vector {x,y} is
// applied in the order 00, 01, 10, 11, held for SETTLE+1 cycles, and the
// gate response z is sampled on the clock edge that ends the hold. Each
// response is compared against the EXPECTED truth table.
//
// Parameters
//   SETTLE    : wait cycles per vector before the sample cycle (1..15)
//   EXPECTED  : expected truth table, bit {x,y} is the expected z
// Ports
//   clk       : single clock, all logic on the rising edge
//   rst_n     : synchronous active-low reset
//   start     : request a test run, only looked at in IDLE
//   x, y      : stimulus driven to the gate under test
//   z         : response from the gate under test
//   busy      : a run is in progress
//   done      : one-cycle pulse at the end of a run
//   pass      : the last run had no mismatches
//   err_count : number of mismatching vectors in the last run (0..4)
//   err_mask  : bit {x,y} set if that vector mismatched
//
// state  | meaning
// IDLE   | waiting for start, stimulus parked at 00, results held
// WAIT   | vector applied, settle counter running down
// SAMPLE | last cycle of a vector, z compared at the closing edge
// DONE   | one-cycle end-of-run pulse, results valid
module gate_checker #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [3:0]  EXPECTED = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       x,
    output logic       y,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_mask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LP_RELOAD = 4'(SETTLE - 1);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_x;
    logic       r_y;
    logic       r_pass;
    logic [2:0] r_err_count;
    logic [3:0] r_err_mask;

    state_t     w_state_nxt;
    logic [1:0] w_idx_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_x_nxt;
    logic       w_y_nxt;
    logic       w_pass_nxt;
    logic [2:0] w_err_count_nxt;
    logic [3:0] w_err_mask_nxt;
    logic [1:0] w_vec;
    logic [1:0] w_idx_inc;
    logic       w_mis;

    assign w_vec     = {r_x, r_y};
    assign w_idx_inc = r_idx + 2'd1;
    assign w_mis     = (z != EXPECTED[w_vec]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_cnt       <= 4'd0;
            r_x         <= 1'b0;
            r_y         <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_err_mask  <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_pass      <= w_pass_nxt;
            r_err_count <= w_err_count_nxt;
            r_err_mask  <= w_err_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_pass_nxt      = r_pass;
        w_err_count_nxt = r_err_count;
        w_err_mask_nxt  = r_err_mask;
        case (r_state)
            IDLE: begin
                w_x_nxt = 1'b0;
                w_y_nxt = 1'b0;
                if (start) begin
                    w_state_nxt     = WAIT;
                    w_idx_nxt       = 2'd0;
                    w_cnt_nxt       = LP_RELOAD;
                    w_pass_nxt      = 1'b0;
                    w_err_count_nxt = 3'd0;
                    w_err_mask_nxt  = 4'd0;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            SAMPLE: begin
                if (w_mis) begin
                    w_err_count_nxt       = r_err_count + 3'd1;
                    w_err_mask_nxt[w_vec] = 1'b1;
                end
                if (r_idx != 2'd3) begin
                    w_idx_nxt          = w_idx_inc;
                    {w_x_nxt, w_y_nxt} = w_idx_inc;
                    w_cnt_nxt          = LP_RELOAD;
                    w_state_nxt        = WAIT;
                end else begin
                    // pass is settled on entry to DONE so it is already valid
                    // during the done pulse, including the final vector's result
                    w_x_nxt     = 1'b0;
                    w_y_nxt     = 1'b0;
                    w_pass_nxt  = (w_err_count_nxt == 3'd0);
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign x         = r_x;
    assign y         = r_y;
    assign busy      = (r_state == WAIT) || (r_state == SAMPLE);
    assign done      = (r_state == DONE);
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign err_mask  = r_err_mask;

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 2: cycles each input vector is held before the response is sampled; legal range 1..15.
REQ-002 SHALL have parameter EXPECTED, default 4'b1000: expected truth table indexed by {x,y} (default = 2-input AND).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request a test run, sampled in IDLE only.
REQ-006 SHALL have port x, output, 1 bit: first input driven to the gate under test.
REQ-007 SHALL have port y, output, 1 bit: second input driven to the gate under test.
REQ-008 SHALL have port z, input, 1 bit: response from the gate under test.
REQ-009 SHALL have port busy, output, 1 bit: run in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at end of run.
REQ-011 SHALL have port pass, output, 1 bit: last run had zero mismatches.
REQ-012 SHALL have port err_count, output, 3 bits: mismatches in last run, 0..4.
REQ-013 SHALL have port err_mask, output, 4 bits: bit {x,y} set if that vector mismatched.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, SAMPLE, DONE.
REQ-015 In IDLE with start=1: next state WAIT; idx=0; {x,y}=2'b00; settle counter=SETTLE-1; busy=1; pass, err_count, err_mask cleared.
REQ-016 In IDLE with start=0: remain in IDLE; x=y=0; results held.
REQ-017 WAIT: decrement counter each cycle; go to SAMPLE when counter is 0; {x,y} stable.
REQ-018 Each vector SHALL be held on {x,y} for exactly SETTLE+1 cycles; z is sampled on the clock edge ending the SAMPLE cycle.
REQ-019 SAMPLE: if z != EXPECTED[{x,y}], increment err_count and set err_mask[{x,y}].
REQ-020 SAMPLE with idx<3: idx+1; {x,y}=idx+1 (x=idx[1], y=idx[0]); counter reloaded to SETTLE-1; go to WAIT.
REQ-021 SAMPLE with idx=3: go to DONE; {x,y} returns to 00.
REQ-022 Vector order SHALL be 00, 01, 10, 11.
REQ-023 DONE lasts exactly one cycle: done=1, busy=0, pass=(err_count==0); then go to IDLE.
REQ-024 done SHALL be high in cycle 4*(SETTLE+1)+1 counted from the start-accepting edge; there SHALL be no other done pulse.
REQ-025 start SHALL be ignored in WAIT, SAMPLE and DONE; start held high SHALL launch a new run only from IDLE.
REQ-026 pass, err_count and err_mask SHALL hold from DONE until the next accepted start.
REQ-027 err_count SHALL never exceed 4.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force, from the next cycle: state IDLE, x=0, y=0, busy=0, done=0, pass=0, err_count=0, err_mask=0, idx=0, counter=0.
REQ-029 Reset SHALL take priority over start and over any state, including mid-vector and DONE.
REQ-030 A run interrupted by reset SHALL produce no done pulse and no partial results.

Verification
REQ-031 Correct AND model, defaults, 1-cycle start pulse -> {x,y} = 00,01,10,11, each held for 3 cycles; done in cycle 13; pass=1, err_count=0, err_mask=0000.
REQ-032 z tied to 0, defaults -> err_count=1, err_mask=1000, pass=0.
REQ-033 OR gate model, EXPECTED=4'b1000 -> err_count=2, err_mask=0110, pass=0; rerun with EXPECTED=4'b1110 -> pass=1.
REQ-034 start held high for 30 cycles, SETTLE=2 -> done pulses in cycles 13 and 27 only; results cleared at the second accepted start.
REQ-035 rst_n=0 for 1 cycle while {x,y}=01 -> next cycle busy=0, x=y=0, err_count=0, pass=0, no done; a later start runs normally.
REQ-036 Gate model with 2-cycle output delay, SETTLE=1 -> pass=0; SETTLE=2 -> pass=1.
